// File: rtl/current_sample_scheduler_if.sv
// ADC reader handshake: acquisition start pulse out, completion pulse and raw phase codes back.
// Signal directions in the names are as seen from the scheduler.
interface current_sample_scheduler_if;
    logic        oAcquire_en;
    logic        iAcquire_done;
    logic [11:0] iIu_raw;
    logic [11:0] iIv_raw;

    modport master (
        output oAcquire_en,
        input  iAcquire_done,
        input  iIu_raw,
        input  iIv_raw
    );

    modport slave (
        input  oAcquire_en,
        output iAcquire_done,
        output iIu_raw,
        output iIv_raw
    );
endinterface

// File: rtl/current_sample_scheduler.sv
// Phase-current acquisition sequencer: PWM-synchronised triggering, completion timeout,
// offset removal, third-phase reconstruction and startup offset calibration.
//
// state    | meaning
// IDLE     | waiting for iPwm_sync or iCal_start
// DELAY    | counting TRIG_DELAY cycles after PWM sync
// TRIG     | one-cycle acquisition start for a normal sample
// WAIT     | waiting for conversion pair, timeout supervised
// OUT      | reconstruct W phase and publish currents
// CAL_TRIG | one-cycle acquisition start for a calibration sample
// CAL_WAIT | waiting for calibration conversion, accumulating
// CAL_FIN  | divide accumulators into new offsets
module current_sample_scheduler #(
    parameter int unsigned CAL_LOG2       = 4,
    parameter int unsigned TRIG_DELAY     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic                       iPwm_sync,
    input  logic                       iCal_start,
    input  logic                       iErr_clr,
    current_sample_scheduler_if.master adc,
    output logic signed [12:0]         oIu,
    output logic signed [12:0]         oIv,
    output logic signed [13:0]         oIw,
    output logic                       oCurrent_valid,
    output logic                       oCal_busy,
    output logic                       oCal_done,
    output logic                       oOverrun,
    output logic                       oTimeout_err
);
    localparam int ACC_W = 12 + CAL_LOG2;
    localparam int CNT_W = CAL_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [15:0]      DLY_LOAD  = (TRIG_DELAY == 0) ? 16'd0 : 16'(TRIG_DELAY - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAL_COUNT = CNT_W'(1 << CAL_LOG2);

    typedef enum logic [2:0] {
        IDLE, DELAY, TRIG, WAIT, OUT, CAL_TRIG, CAL_WAIT, CAL_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        dly_q, dly_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_u_q, acc_u_d, acc_v_q, acc_v_d;
    logic [11:0]        off_u_q, off_u_d, off_v_q, off_v_d;
    logic signed [12:0] iu_q, iu_d, iv_q, iv_d;
    logic signed [13:0] iw_q, iw_d;
    logic signed [13:0] sum_uv;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic               terr_q, terr_d;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            dly_q   <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            acc_u_q <= '0;
            acc_v_q <= '0;
            off_u_q <= 12'd2048;
            off_v_q <= 12'd2048;
            iu_q    <= '0;
            iv_q    <= '0;
            iw_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            acc_u_q <= acc_u_d;
            acc_v_q <= acc_v_d;
            off_u_q <= off_u_d;
            off_v_q <= off_v_d;
            iu_q    <= iu_d;
            iv_q    <= iv_d;
            iw_q    <= iw_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        acc_u_d = acc_u_q;
        acc_v_d = acc_v_q;
        off_u_d = off_u_q;
        off_v_d = off_v_q;
        iu_d    = iu_q;
        iv_d    = iv_q;
        iw_d    = iw_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        terr_d  = terr_q;
        sum_uv  = {iu_q[12], iu_q} + {iv_q[12], iv_q};

        // Clear first so that any set condition below overrides it.
        if (iErr_clr) begin
            ovr_d  = 1'b0;
            terr_d = 1'b0;
        end
        if (iPwm_sync && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (iCal_start) begin
                    state_d = CAL_TRIG;
                    acc_u_d = '0;
                    acc_v_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (iPwm_sync) begin
                    if (TRIG_DELAY == 0) begin
                        state_d = TRIG;
                    end else begin
                        state_d = DELAY;
                        dly_d   = DLY_LOAD;
                    end
                end
            end
            DELAY: begin
                if (dly_q == 16'd0) begin
                    state_d = TRIG;
                end else begin
                    dly_d = dly_q - 16'd1;
                end
            end
            TRIG: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (adc.iAcquire_done) begin
                    iu_d    = {1'b0, adc.iIu_raw} - {1'b0, off_u_q};
                    iv_d    = {1'b0, adc.iIv_raw} - {1'b0, off_v_q};
                    state_d = OUT;
                end else if (tmo_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            OUT: begin
                iw_d    = -sum_uv;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            CAL_TRIG: begin
                tmo_d   = '0;
                state_d = CAL_WAIT;
            end
            CAL_WAIT: begin
                if (adc.iAcquire_done) begin
                    acc_u_d = acc_u_q + ACC_W'(adc.iIu_raw);
                    acc_v_d = acc_v_q + ACC_W'(adc.iIv_raw);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_d == CAL_COUNT) ? CAL_FIN : CAL_TRIG;
                end else if (tmo_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CAL_FIN: begin
                off_u_d = acc_u_q[ACC_W-1:CAL_LOG2];
                off_v_d = acc_v_q[ACC_W-1:CAL_LOG2];
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign adc.oAcquire_en = (state_q == TRIG) || (state_q == CAL_TRIG);
    assign oIu             = iu_q;
    assign oIv             = iv_q;
    assign oIw             = iw_q;
    assign oCurrent_valid  = valid_q;
    assign oCal_busy       = busy_q;
    assign oCal_done       = done_q;
    assign oOverrun        = ovr_q;
    assign oTimeout_err    = terr_q;
endmodule

// File: tb/tb_current_sample_scheduler.sv
// Directed bench for current_sample_scheduler: instance A (no trigger delay) and
// instance B (50-cycle trigger delay), all expected values hand-computed.
`timescale 1ns/1ps
module tb_current_sample_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sync_a, cal_a, clr_a, sync_b, cal_b, clr_b;
    logic signed [12:0] iu_a, iv_a, iu_b, iv_b;
    logic signed [13:0] iw_a, iw_b;
    logic valid_a, busy_a, cdone_a, ovr_a, terr_a;
    logic valid_b, busy_b, cdone_b, ovr_b, terr_b;

    current_sample_scheduler_if adc_a ();
    current_sample_scheduler_if adc_b ();

    current_sample_scheduler #(.TRIG_DELAY(0)) dut_a (
        .iClk(clk), .iRst_n(rst_n), .iPwm_sync(sync_a), .iCal_start(cal_a), .iErr_clr(clr_a),
        .adc(adc_a.master), .oIu(iu_a), .oIv(iv_a), .oIw(iw_a), .oCurrent_valid(valid_a),
        .oCal_busy(busy_a), .oCal_done(cdone_a), .oOverrun(ovr_a), .oTimeout_err(terr_a)
    );

    current_sample_scheduler #(.TRIG_DELAY(50)) dut_b (
        .iClk(clk), .iRst_n(rst_n), .iPwm_sync(sync_b), .iCal_start(cal_b), .iErr_clr(clr_b),
        .adc(adc_b.master), .oIu(iu_b), .oIv(iv_b), .oIw(iw_b), .oCurrent_valid(valid_b),
        .oCal_busy(busy_b), .oCal_done(cdone_b), .oOverrun(ovr_b), .oTimeout_err(terr_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int acq_cnt_a = 0, acq_cnt_b = 0, val_cnt_a = 0;

    always @(posedge clk) begin
        if (adc_a.oAcquire_en) acq_cnt_a++;
        if (adc_b.oAcquire_en) acq_cnt_b++;
        if (valid_a) val_cnt_a++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic done_a(input int u, input int v);
        adc_a.iAcquire_done = 1'b1;
        adc_a.iIu_raw = 12'(u);
        adc_a.iIv_raw = 12'(v);
        tick();
        adc_a.iAcquire_done = 1'b0;
        adc_a.iIu_raw = '0;
        adc_a.iIv_raw = '0;
    endtask

    // Full normal sample on A starting from IDLE at a falling edge.
    task automatic sample_a(input string tag, input int u, input int v,
                            input int eu, input int ev, input int ew);
        sync_a = 1'b1;
        tick();
        sync_a = 1'b0;
        check({tag, "_acq"}, int'(adc_a.oAcquire_en), 1);
        tick();
        done_a(u, v);
        check({tag, "_valid_d1"}, int'(valid_a), 0);
        tick();
        check({tag, "_valid_d2"}, int'(valid_a), 1);
        check({tag, "_iu"}, int'(iu_a), eu);
        check({tag, "_iv"}, int'(iv_a), ev);
        check({tag, "_iw"}, int'(iw_a), ew);
        tick();
        check({tag, "_valid_d3"}, int'(valid_a), 0);
    endtask

    task automatic start_cal_a();
        cal_a = 1'b1;
        tick();
        cal_a = 1'b0;
    endtask

    task automatic run_cal_a(input string tag, input int n, input int u, input int v);
        bit found;
        for (int i = 0; i < n; i++) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (adc_a.oAcquire_en) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            check({tag, "_acq_seen"}, int'(found), 1);
            check({tag, "_busy"}, int'(busy_a), 1);
            tick();
            done_a(u, v);
        end
    endtask

    int ac, vc, ab;

    initial begin
        rst_n = 1'b0;
        {sync_a, cal_a, clr_a, sync_b, cal_b, clr_b} = '0;
        adc_a.iAcquire_done = 1'b0; adc_a.iIu_raw = '0; adc_a.iIv_raw = '0;
        adc_b.iAcquire_done = 1'b0; adc_b.iIu_raw = '0; adc_b.iIv_raw = '0;
        tick(2);
        check("rst_iu", int'(iu_a), 0);
        check("rst_iv", int'(iv_a), 0);
        check("rst_iw", int'(iw_a), 0);
        check("rst_valid", int'(valid_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_cdone", int'(cdone_a), 0);
        check("rst_ovr", int'(ovr_a), 0);
        check("rst_terr", int'(terr_a), 0);
        check("rst_acq", int'(adc_a.oAcquire_en), 0);
        rst_n = 1'b1;
        tick(2);

        // Delayed trigger and overrun on B
        ab = acq_cnt_b;
        sync_b = 1'b1; tick(); sync_b = 1'b0;
        check("t4_acq_c1", int'(adc_b.oAcquire_en), 0);
        tick(49);
        check("t4_acq_c50", int'(adc_b.oAcquire_en), 0);
        tick();
        check("t4_acq_c51", int'(adc_b.oAcquire_en), 1);
        tick();
        sync_b = 1'b1; tick(); sync_b = 1'b0;
        check("t4_ovr_set", int'(ovr_b), 1);
        adc_b.iAcquire_done = 1'b1; adc_b.iIu_raw = 12'd2148; adc_b.iIv_raw = 12'd1948;
        tick();
        adc_b.iAcquire_done = 1'b0;
        tick();
        check("t4_valid", int'(valid_b), 1);
        check("t4_iu", int'(iu_b), 100);
        check("t4_iv", int'(iv_b), -100);
        check("t4_iw", int'(iw_b), 0);
        check("t4_one_trig", acq_cnt_b - ab, 1);
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        check("t4_ovr_clr", int'(ovr_b), 0);
        sync_b = 1'b1; tick();
        clr_b = 1'b1; tick();
        sync_b = 1'b0; clr_b = 1'b0;
        check("t4_set_wins", int'(ovr_b), 1);
        tick(60);
        adc_b.iAcquire_done = 1'b1; tick(); adc_b.iAcquire_done = 1'b0;
        tick(3);
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        check("t4_ovr_clr2", int'(ovr_b), 0);

        // Default offsets
        sample_a("t1", 2148, 1948, 100, -100, 0);
        tick(3);
        check("t1_hold_iu", int'(iu_a), 100);
        sample_a("t3_max", 4095, 4095, 2047, 2047, -4094);
        sample_a("t3_min", 0, 0, -2048, -2048, 4096);

        // Normal timeout
        vc = val_cnt_a;
        sync_a = 1'b1; tick(); sync_a = 1'b0;
        check("t5_acq", int'(adc_a.oAcquire_en), 1);
        tick(1999);
        check("t5_terr_c1999", int'(terr_a), 0);
        tick();
        check("t5_terr_c2000", int'(terr_a), 0);
        tick();
        check("t5_terr_c2001", int'(terr_a), 1);
        check("t5_no_valid", val_cnt_a - vc, 0);
        sample_a("t5_after", 2148, 1948, 100, -100, 0);
        check("t5_terr_sticky", int'(terr_a), 1);
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        check("t5_terr_clr", int'(terr_a), 0);

        // Calibration
        ac = acq_cnt_a; vc = val_cnt_a;
        start_cal_a();
        check("t2_busy_start", int'(busy_a), 1);
        check("t2_cdone_start", int'(cdone_a), 0);
        run_cal_a("t2", 16, 2060, 2030);
        tick();
        check("t2_busy_end", int'(busy_a), 0);
        check("t2_cdone_end", int'(cdone_a), 1);
        tick(3);
        check("t2_acq_count", acq_cnt_a - ac, 16);
        check("t2_no_valid", val_cnt_a - vc, 0);
        sample_a("t2_post", 2060, 2000, 0, -30, 30);

        // Calibration timeout keeps old offsets
        start_cal_a();
        check("t5c_cdone_clr", int'(cdone_a), 0);
        run_cal_a("t5c", 3, 2500, 2500);
        tick(2005);
        check("t5c_busy", int'(busy_a), 0);
        check("t5c_cdone", int'(cdone_a), 0);
        check("t5c_terr", int'(terr_a), 1);
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        sample_a("t5c_post", 2060, 2000, 0, -30, 30);

        // Reset mid-calibration
        start_cal_a();
        run_cal_a("t6a", 7, 3000, 1000);
        rst_n = 1'b0;
        #1;
        check("t6_rst_iu", int'(iu_a), 0);
        check("t6_rst_iv", int'(iv_a), 0);
        check("t6_rst_iw", int'(iw_a), 0);
        check("t6_rst_busy", int'(busy_a), 0);
        check("t6_rst_cdone", int'(cdone_a), 0);
        check("t6_rst_acq", int'(adc_a.oAcquire_en), 0);
        tick();
        rst_n = 1'b1;
        tick(2);
        sample_a("t6_defoff", 2148, 1948, 100, -100, 0);
        ac = acq_cnt_a;
        start_cal_a();
        run_cal_a("t6b", 16, 2100, 1990);
        tick();
        check("t6_cdone", int'(cdone_a), 1);
        tick(2);
        check("t6_acq_count", acq_cnt_a - ac, 16);
        sample_a("t6_post", 2100, 2100, 0, 110, -110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/current_sample_scheduler.md
Name: current_sample_scheduler

Overview:
- Sequences the two-channel phase-current ADC front end for the FOC loop.
- Fires one acquisition per PWM sync event, after a programmable delay, and supervises completion with a timeout.
- Removes per-channel zero-current offsets and reconstructs the third phase current.
- Provides a startup offset-calibration sequence that averages 2^CAL_LOG2 back-to-back acquisitions.

Parameters:
- CAL_LOG2, 4, log2 of the number of calibration samples (16 by default).
- TRIG_DELAY, 0, iClk cycles from iPwm_sync to oAcquire_en (0..65535).
- TIMEOUT_CYCLES, 2000, iClk cycles allowed from oAcquire_en to iAcquire_done.

Ports:
- iClk, input, 1, system clock (100 MHz).
- iRst_n, input, 1, asynchronous active-low reset.
- iPwm_sync, input, 1, one-cycle pulse at the PWM counter peak.
- iCal_start, input, 1, one-cycle pulse that requests offset calibration.
- iErr_clr, input, 1, one-cycle pulse that clears sticky errors.
- iAcquire_done, input, 1, one-cycle pulse from the ADC reader when a conversion pair is complete.
- iIu_raw, input, 12, unsigned U-phase code; valid when iAcquire_done=1.
- iIv_raw, input, 12, unsigned V-phase code; valid when iAcquire_done=1.
- oAcquire_en, output, 1, one-cycle pulse that starts an ADC acquisition.
- oIu, output, 13, signed U current (iIu_raw minus U offset).
- oIv, output, 13, signed V current (iIv_raw minus V offset).
- oIw, output, 14, signed W current, equal to -(oIu+oIv).
- oCurrent_valid, output, 1, one-cycle pulse when oIu/oIv/oIw update.
- oCal_busy, output, 1, high while calibration is running.
- oCal_done, output, 1, high once a calibration has completed.
- oOverrun, output, 1, sticky; an iPwm_sync arrived while the block was not IDLE.
- oTimeout_err, output, 1, sticky; an acquisition timed out.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Offset registers are 12'd2048.
  - Accumulator, sample counter, delay counter and timeout counter are 0.
  - State is IDLE.
- States: IDLE, DELAY, TRIG, WAIT, OUT, CAL_TRIG, CAL_WAIT, CAL_FIN.
- IDLE:
  - If iCal_start=1, go to CAL_TRIG, clear the accumulator and sample counter, set oCal_busy=1 and oCal_done=0. iCal_start has priority over iPwm_sync in the same cycle.
  - Else if iPwm_sync=1: go to TRIG when TRIG_DELAY=0, otherwise go to DELAY.
- DELAY: count TRIG_DELAY cycles, then go to TRIG.
- TRIG: assert oAcquire_en for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - On iAcquire_done, register oIu={1'b0,iIu_raw}-{1'b0,offU} and oIv likewise (13-bit signed), then go to OUT.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no done, set oTimeout_err and go to IDLE with no valid pulse.
- OUT: oIw = -(sext(oIu)+sext(oIv)) in 14 bits. Assert oCurrent_valid for one cycle; oIu/oIv/oIw are all stable in that cycle. Return to IDLE.
- Latency: oCurrent_valid rises exactly 2 cycles after the iAcquire_done cycle. All current outputs hold their values between updates.
- CAL_TRIG: oAcquire_en pulse, then go to CAL_WAIT.
- CAL_WAIT:
  - On iAcquire_done, add the raw codes into accU/accV (each 12+CAL_LOG2 bits, no overflow possible) and increment the counter.
  - If the counter reaches 2^CAL_LOG2, go to CAL_FIN; otherwise go to CAL_TRIG on the next cycle.
  - Timeout behaves as in WAIT: set oTimeout_err, clear oCal_busy, keep the old offsets, leave oCal_done=0, return to IDLE.
- CAL_FIN:
  - offU = accU>>CAL_LOG2 and offV = accV>>CAL_LOG2 (truncate).
  - oCal_busy=0, oCal_done=1, go to IDLE.
  - Calibration never asserts oCurrent_valid.
- Sampling is allowed before calibration, using the default offsets of 2048.
- iPwm_sync outside IDLE: ignored and sets oOverrun.
- iCal_start outside IDLE: ignored and sets no flag.
- iAcquire_done outside WAIT/CAL_WAIT: ignored.
- iErr_clr clears oOverrun and oTimeout_err. If a set condition occurs in the same cycle, set wins.
- Reset asserted mid-operation returns everything to reset values immediately, including the offsets.

Test Plan:
1. Reset, then iPwm_sync with TRIG_DELAY=0 → oAcquire_en one cycle later. Return done with Iu_raw=2148, Iv_raw=1948 → oIu=+100, oIv=-100, oIw=0, with oCurrent_valid 2 cycles after done.
2. iCal_start with the model returning U=2060 and V=2030 on all 16 samples → 16 oAcquire_en pulses, oCal_busy high throughout, then oCal_done=1. A following sample with U=2060 and V=2000 → oIu=0, oIv=-30, oIw=+30.
3. Extremes with default offsets: Iu_raw=4095, Iv_raw=4095 → oIu=oIv=2047, oIw=-4094. Iu_raw=Iv_raw=0 → oIu=oIv=-2048, oIw=+4096.
4. TRIG_DELAY=50 → oAcquire_en exactly 51 cycles after iPwm_sync. A second iPwm_sync during WAIT → oOverrun=1 and no extra trigger; iErr_clr then clears it.
5. Withhold iAcquire_done → oTimeout_err set at TIMEOUT_CYCLES, no oCurrent_valid, block returns to IDLE. The same test during calibration → oCal_busy=0, oCal_done=0, offsets unchanged.
6. Assert iRst_n low mid-calibration after 7 samples → all outputs are 0 and offsets return to 2048. A fresh calibration then completes with 16 samples.
